// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the register file with busy scoreboard:
// default sizes, the hardwired-zero register index and an address-width helper.
package regfile_sb_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int REG_ZERO = 0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rf_busy_table.sv
// Per-register busy scoreboard: issue sets, writeback clears, issue wins on a
// same-edge collision. Also keeps a registered running count of busy registers.
module rf_busy_table
  import regfile_sb_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NWR  = 2,
  localparam int AW  = clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] waddr,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic [NREG-1:0]   busy,
  output logic [AW:0]       busy_cnt
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [NREG-1:0] clr;
  logic [NREG-1:0] nxt;
  logic [AW:0]     ups;
  logic [AW:0]     downs;

  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    clr   = '0;
    ups   = '0;
    downs = '0;
    for (int w = 0; w < NWR; w++) begin
      if (we[w] && waddr[w*AW +: AW] != ZERO_ADDR) clr[waddr[w*AW +: AW]] = 1'b1;
    end
    nxt = busy & ~clr;
    // Set applied after clear: a new producer issued this cycle owns the register.
    if (iss_valid && iss_rd != ZERO_ADDR) nxt[iss_rd] = 1'b1;
    nxt[REG_ZERO] = 1'b0;
    for (int k = 0; k < NREG; k++) begin
      ups   = ups   + (AW+1)'(nxt[k] & ~busy[k]);
      downs = downs + (AW+1)'(busy[k] & ~nxt[k]);
    end
  end

  // NOTE: non-blocking so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= nxt;
      busy_cnt <= busy_cnt + ups - downs;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with R0 hardwired to zero, optional write-to-read
// bypass and a busy scoreboard flagging reads of registers still in flight.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic [AW:0]         busy_cnt
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NRD-1:0]  hit;
  logic [XLEN-1:0] fwd [NRD];

  // NOTE: the array is cleared by reset, so it must map to flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NREG; k++) regs[k] <= '0;
    end else begin
      // Ascending port order: the highest-index writer to an address lands last.
      for (int w = 0; w < NWR; w++) begin
        if (we[w] && waddr[w*AW +: AW] != ZERO_ADDR)
          regs[waddr[w*AW +: AW]] <= wdata[w*XLEN +: XLEN];
      end
    end
  end

  // Same-cycle write match per read port, resolved with the same priority as storage.
  always_comb begin
    hit = '0;
    for (int p = 0; p < NRD; p++) begin
      fwd[p] = '0;
      for (int w = 0; w < NWR; w++) begin
        if (we[w] && raddr[p*AW +: AW] != ZERO_ADDR && waddr[w*AW +: AW] == raddr[p*AW +: AW]) begin
          hit[p] = 1'b1;
          fwd[p] = wdata[w*XLEN +: XLEN];
        end
      end
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] ra;
    logic          bypass_hit;
    assign ra         = raddr[p*AW +: AW];
    assign bypass_hit = (BYPASS != 0) && hit[p];
    assign rdata[p*XLEN +: XLEN] = (ra == ZERO_ADDR) ? '0 : bypass_hit ? fwd[p] : regs[ra];
    assign rbusy[p]   = (ra != ZERO_ADDR) && busy[ra] && !bypass_hit;
  end

  rf_busy_table #(
    .NREG (NREG),
    .NWR  (NWR)
  ) u_busy (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .waddr     (waddr),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .busy      (busy),
    .busy_cnt  (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed vector table, reset/scoreboard sequences and a modelled random stream
// for regfile_sb (3R/2W, 16 regs, bypass) plus a 1R/1W non-bypass instance.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] raddr;
  logic [95:0] rdata;
  logic [2:0]  rbusy;
  logic [1:0]  we;
  logic [7:0]  waddr;
  logic [63:0] wdata;
  logic        iss_valid;
  logic [3:0]  iss_rd;
  logic [4:0]  busy_cnt;

  logic [3:0]  nb_raddr;
  logic [31:0] nb_rdata;
  logic [0:0]  nb_rbusy;
  logic [0:0]  nb_we;
  logic [3:0]  nb_waddr;
  logic [31:0] nb_wdata;
  logic        nb_iss_valid;
  logic [3:0]  nb_iss_rd;
  logic [4:0]  nb_busy_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(32), .NREG(16), .NRD(3), .NWR(2), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .busy_cnt(busy_cnt)
  );

  regfile_sb #(.XLEN(32), .NREG(16), .NRD(1), .NWR(1), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .raddr(nb_raddr), .rdata(nb_rdata), .rbusy(nb_rbusy),
    .we(nb_we), .waddr(nb_waddr), .wdata(nb_wdata), .iss_valid(nb_iss_valid),
    .iss_rd(nb_iss_rd), .busy_cnt(nb_busy_cnt)
  );

  typedef struct {
    logic [1:0]       we;
    logic [3:0]       wa0, wa1;
    logic [31:0]      wd0, wd1;
    logic             iv;
    logic [3:0]       ird;
    logic [3:0]       ra0, ra1, ra2;
    logic [2:0][31:0] ed;
    logic [2:0]       eb;
    logic [4:0]       ec;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(logic [1:0] w, logic [3:0] a0, logic [31:0] d0,
                              logic [3:0] a1, logic [31:0] d1, logic iv, logic [3:0] ird,
                              logic [3:0] r0, logic [3:0] r1, logic [3:0] r2,
                              logic [31:0] e0, logic [31:0] e1, logic [31:0] e2,
                              logic [2:0] eb, logic [4:0] ec);
    vec_t v;
    v.we = w; v.wa0 = a0; v.wd0 = d0; v.wa1 = a1; v.wd1 = d1;
    v.iv = iv; v.ird = ird; v.ra0 = r0; v.ra1 = r1; v.ra2 = r2;
    v.ed = {e2, e1, e0}; v.eb = eb; v.ec = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    we = '0; waddr = '0; wdata = '0; iss_valid = 1'b0; iss_rd = '0;
    nb_we = '0; nb_waddr = '0; nb_wdata = '0; nb_iss_valid = 1'b0; nb_iss_rd = '0;
  endtask

  logic [31:0] mregs [16];
  logic [15:0] mbusy;

  initial begin
    reset = 1'b1;
    raddr = '0; nb_raddr = '0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state on every port of every register.
    for (int a = 0; a < 16; a++) begin
      raddr = {4'(a), 4'(a), 4'(a)};
      #1;
      check($sformatf("reset rdata R%0d", a), rdata, 96'd0);
      check($sformatf("reset rbusy R%0d", a), {61'd0, rbusy}, 64'd0);
    end
    check("reset busy_cnt", {59'd0, busy_cnt}, 64'd0);

    vecs[0]  = mk(2'b01, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3'b000, 0);
    vecs[1]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 15, 7, 0, 0, 0, 3'b000, 0);
    vecs[2]  = mk(2'b01, 5, 32'h1234, 0, 0, 0, 0, 5, 5, 0, 32'h1234, 32'h1234, 0, 3'b000, 0);
    vecs[3]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 5, 0, 5, 32'h1234, 0, 32'h1234, 3'b000, 0);
    vecs[4]  = mk(2'b11, 7, 32'hAAAA, 7, 32'h5555, 0, 0, 7, 5, 0, 32'h5555, 32'h1234, 0, 3'b000, 0);
    vecs[5]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 7, 7, 7, 32'h5555, 32'h5555, 32'h5555, 3'b000, 0);
    vecs[6]  = mk(2'b00, 0, 0, 0, 0, 1, 9, 9, 0, 7, 0, 0, 32'h5555, 3'b000, 0);
    vecs[7]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 9, 9, 5, 0, 0, 32'h1234, 3'b011, 1);
    vecs[8]  = mk(2'b10, 0, 0, 9, 32'h42, 0, 0, 9, 9, 7, 32'h42, 32'h42, 32'h5555, 3'b000, 1);
    vecs[9]  = mk(2'b01, 9, 32'h77, 0, 0, 1, 9, 9, 5, 9, 32'h77, 32'h1234, 32'h77, 3'b000, 0);
    vecs[10] = mk(2'b00, 0, 0, 0, 0, 0, 0, 9, 0, 9, 32'h77, 0, 32'h77, 3'b101, 1);
    vecs[11] = mk(2'b00, 0, 0, 0, 0, 1, 9, 9, 9, 9, 32'h77, 32'h77, 32'h77, 3'b111, 1);
    vecs[12] = mk(2'b00, 0, 0, 0, 0, 1, 0, 9, 0, 9, 32'h77, 0, 32'h77, 3'b101, 1);
    vecs[13] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 9, 5, 0, 32'h77, 32'h1234, 3'b010, 1);
    vecs[14] = mk(2'b11, 9, 32'h1, 3, 32'h3, 0, 0, 9, 3, 9, 32'h1, 32'h3, 32'h1, 3'b000, 1);
    vecs[15] = mk(2'b00, 0, 0, 0, 0, 0, 0, 9, 3, 7, 32'h1, 32'h3, 32'h5555, 3'b000, 0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      we = vecs[i].we; waddr = {vecs[i].wa1, vecs[i].wa0}; wdata = {vecs[i].wd1, vecs[i].wd0};
      iss_valid = vecs[i].iv; iss_rd = vecs[i].ird;
      raddr = {vecs[i].ra2, vecs[i].ra1, vecs[i].ra0};
      #1;
      for (int p = 0; p < 3; p++)
        check($sformatf("vec%0d rdata%0d", i, p), {32'd0, rdata[p*32 +: 32]}, {32'd0, vecs[i].ed[p]});
      check($sformatf("vec%0d rbusy", i), {61'd0, rbusy}, {61'd0, vecs[i].eb});
      check($sformatf("vec%0d busy_cnt", i), {59'd0, busy_cnt}, {59'd0, vecs[i].ec});
    end

    // Three producers in flight, then reset with a competing issue and writes.
    @(negedge clk); idle(); iss_valid = 1'b1; iss_rd = 4'd3; we = 2'b01; waddr = 8'h0A; wdata = 64'hA;
    @(negedge clk); idle(); iss_valid = 1'b1; iss_rd = 4'd4;
    @(negedge clk); idle(); iss_valid = 1'b1; iss_rd = 4'd5;
    @(negedge clk); idle(); we = 2'b01; waddr = 8'h0B; wdata = 64'h99; raddr = {4'd5, 4'd4, 4'd3};
    #1;
    check("pre-reset rbusy", {61'd0, rbusy}, 64'b111);
    check("pre-reset busy_cnt", {59'd0, busy_cnt}, 64'd3);
    @(negedge clk);
    idle(); reset = 1'b1; iss_valid = 1'b1; iss_rd = 4'd6;
    we = 2'b11; waddr = {4'd3, 4'd12}; wdata = {32'h33, 32'h55};
    @(negedge clk);
    idle(); reset = 1'b0; raddr = {4'd5, 4'd3, 4'd6};
    #1;
    check("post-reset rbusy", {61'd0, rbusy}, 64'd0);
    check("post-reset busy_cnt", {59'd0, busy_cnt}, 64'd0);
    check("post-reset rdata", rdata, 96'd0);
    raddr = {4'd12, 4'd11, 4'd10};
    #1;
    check("post-reset written regs", rdata, 96'd0);

    // Non-bypass instance: same-cycle write is not seen, busy persists until the edge.
    @(negedge clk); idle(); nb_we = 1'b1; nb_waddr = 4'd5; nb_wdata = 32'h1234; nb_raddr = 4'd5;
    #1; check("nb same-cycle rdata", {32'd0, nb_rdata}, 64'd0);
    @(negedge clk); idle(); nb_iss_valid = 1'b1; nb_iss_rd = 4'd5;
    #1; check("nb next-cycle rdata", {32'd0, nb_rdata}, 64'h1234);
    check("nb rbusy before issue edge", {63'd0, nb_rbusy}, 64'd0);
    @(negedge clk); idle(); nb_we = 1'b1; nb_waddr = 4'd5; nb_wdata = 32'h9;
    #1; check("nb rbusy during write", {63'd0, nb_rbusy}, 64'd1);
    check("nb rdata during write", {32'd0, nb_rdata}, 64'h1234);
    check("nb busy_cnt during write", {59'd0, nb_busy_cnt}, 64'd1);
    @(negedge clk); idle();
    #1; check("nb rbusy after write", {63'd0, nb_rbusy}, 64'd0);
    check("nb rdata after write", {32'd0, nb_rdata}, 64'h9);
    check("nb busy_cnt after write", {59'd0, nb_busy_cnt}, 64'd0);

    // Random issue/write stream against a reference model, starting from reset.
    @(negedge clk); idle(); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 16; k++) mregs[k] = '0;
    mbusy = '0;
    for (int c = 0; c < 400; c++) begin
      logic [3:0]  wa [2];
      logic [31:0] wd [2];
      logic [3:0]  ra;
      logic [31:0] ed;
      logic        eb;
      logic        h;
      we = 2'($urandom_range(0, 3));
      for (int w = 0; w < 2; w++) begin
        wa[w] = 4'($urandom_range(0, 15));
        wd[w] = $urandom;
      end
      waddr = {wa[1], wa[0]}; wdata = {wd[1], wd[0]};
      iss_valid = ($urandom_range(0, 2) != 0);
      iss_rd = 4'($urandom_range(0, 15));
      raddr = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      #1;
      for (int p = 0; p < 3; p++) begin
        ra = raddr[p*4 +: 4];
        h  = 1'b0;
        ed = mregs[ra];
        for (int w = 0; w < 2; w++)
          if (we[w] && wa[w] == ra) begin h = 1'b1; ed = wd[w]; end
        if (ra == 4'd0) begin ed = '0; eb = 1'b0; end
        else eb = mbusy[ra] && !h;
        check($sformatf("rand%0d rdata%0d", c, p), {32'd0, rdata[p*32 +: 32]}, {32'd0, ed});
        check($sformatf("rand%0d rbusy%0d", c, p), {63'd0, rbusy[p]}, {63'd0, eb});
      end
      check($sformatf("rand%0d busy_cnt", c), {59'd0, busy_cnt}, 64'($countones(mbusy)));
      for (int w = 0; w < 2; w++)
        if (we[w] && wa[w] != 4'd0) begin mregs[wa[w]] = wd[w]; mbusy[wa[w]] = 1'b0; end
      if (iss_valid && iss_rd != 4'd0) mbusy[iss_rd] = 1'b1;
      @(negedge clk);
    end
    idle();
    #1;
    check("rand final busy_cnt", {59'd0, busy_cnt}, 64'($countones(mbusy)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
